// File: rtl/qn_daq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qn_daq_pkg : shared constants and FSM encoding for the tube event builder
// Rev 1.0
// ---------------------------------------------------------------------------
package qn_daq_pkg;

  localparam logic [3:0] HDR_TAG   = 4'hE;
  localparam int         OWORD_W   = 16;
  localparam int         EVT_CNT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_CHECK  = 2'd2,
    ST_WRITE  = 2'd3
  } builder_state_e;

  // One header word followed by the hit map packed into output words.
  function automatic int words_per_evt(input int n_wires);
    return 1 + n_wires / OWORD_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tube_event_builder_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with registered read data and valid strobe
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop     = rd_en && (count_q != '0);
    // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
    do_push    = wr_en && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rd_data_d  = do_pop ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = do_pop;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/tube_event_builder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tube_event_builder : coincidence-triggered drift-tube hit map builder with FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module tube_event_builder
  import qn_daq_pkg::*;
#(
  parameter int NUM_LAYERS      = 4,
  parameter int WIRES_PER_LAYER = 8,
  parameter int PRE_CYCLES      = 4,
  parameter int WINDOW_CYCLES   = 20,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                                  clk100,
  input  logic                                  reset,
  input  logic                                  SCIN_COIN,
  input  logic [NUM_LAYERS*WIRES_PER_LAYER-1:0] TUBE_HITS,
  input  logic                                  RD_EN,
  output logic [OWORD_W-1:0]                    OTUBE,
  output logic                                  RD_VALID,
  output logic                                  RD_EMPTY,
  output logic                                  overflowLight,
  output logic [EVT_CNT_W-1:0]                  evt_count
);

  localparam int N_WIRES       = NUM_LAYERS * WIRES_PER_LAYER;
  localparam int N_DATA_WORDS  = N_WIRES / OWORD_W;
  localparam int WORDS_PER_EVT = words_per_evt(N_WIRES);
  localparam int IDX_W         = $clog2(WORDS_PER_EVT);
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;

  builder_state_e       state_q, state_d;
  logic [N_WIRES-1:0]   hist_q [PRE_CYCLES];
  logic [N_WIRES-1:0]   hist_d [PRE_CYCLES];
  logic [N_WIRES-1:0]   hist_or;
  logic [N_WIRES-1:0]   capture_q, capture_d;
  logic [7:0]           win_cnt_q, win_cnt_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [EVT_CNT_W-1:0] evt_count_q, evt_count_d;
  logic                 overflow_q, overflow_d;
  logic                 coin_prev_q;
  logic                 trigger;

  logic                 push;
  logic [OWORD_W-1:0]   push_data;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 pop;
  int                   free_words;

  always_comb begin
    hist_d[0] = TUBE_HITS;
    for (int i = 1; i < PRE_CYCLES; i++) hist_d[i] = hist_q[i-1];
    hist_or = '0;
    for (int i = 0; i < PRE_CYCLES; i++) hist_or = hist_or | hist_q[i];
  end

  assign trigger = SCIN_COIN && !coin_prev_q;
  assign pop     = RD_EN && !fifo_empty;
  // Counting a same-cycle pop lets a draining reader free room for the next event.
  assign free_words = FIFO_DEPTH - int'(fifo_count) + int'(pop);

  always_comb begin
    push_data = {HDR_TAG, evt_count_q};
    for (int k = 0; k < N_DATA_WORDS; k++) begin
      if (int'(wr_idx_q) == k + 1) push_data = capture_q[k*OWORD_W +: OWORD_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    capture_d   = capture_q;
    win_cnt_d   = win_cnt_q;
    wr_idx_d    = wr_idx_q;
    evt_count_d = evt_count_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          capture_d = hist_or | TUBE_HITS;
          win_cnt_d = 8'(WINDOW_CYCLES - 1);
          state_d   = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        capture_d = capture_q | TUBE_HITS;
        if (win_cnt_q == 8'd0) state_d = ST_CHECK;
        else                   win_cnt_d = win_cnt_q - 8'd1;
      end
      ST_CHECK: begin
        wr_idx_d = '0;
        if (free_words >= WORDS_PER_EVT) begin
          state_d = ST_WRITE;
        end else begin
          overflow_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_WRITE: begin
        push = 1'b1;
        if (int'(wr_idx_q) == WORDS_PER_EVT - 1) begin
          evt_count_d = evt_count_q + EVT_CNT_W'(1);
          state_d     = ST_IDLE;
        end else begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      capture_q   <= '0;
      win_cnt_q   <= '0;
      wr_idx_q    <= '0;
      evt_count_q <= '0;
      overflow_q  <= 1'b0;
      coin_prev_q <= 1'b0;
      for (int i = 0; i < PRE_CYCLES; i++) hist_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      capture_q   <= capture_d;
      win_cnt_q   <= win_cnt_d;
      wr_idx_q    <= wr_idx_d;
      evt_count_q <= evt_count_d;
      overflow_q  <= overflow_d;
      coin_prev_q <= SCIN_COIN;
      hist_q      <= hist_d;
    end
  end

  sync_fifo #(
    .WIDTH (OWORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk100),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (push_data),
    .rd_en    (RD_EN),
    .rd_data  (OTUBE),
    .rd_valid (RD_VALID),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign RD_EMPTY      = fifo_empty;
  assign overflowLight = overflow_q;
  assign evt_count     = evt_count_q;

endmodule
`default_nettype wire
